// File: rtl/pdm_tx_if.sv
// Sample handshake, command and PDM output bundle for pdm_tx.
// The master side drives commands and PCM samples; the slave side is the modulator.
interface pdm_tx_if;
  logic [1:0]  ctrl;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        pdm_clk_o;
  logic        pdm_out;
  logic        bsy;
  logic        underrun;

  modport master (
    output ctrl, din, din_valid,
    input  din_ready, pdm_clk_o, pdm_out, bsy, underrun
  );

  modport slave (
    input  ctrl, din, din_valid,
    output din_ready, pdm_clk_o, pdm_out, bsy, underrun
  );
endinterface

// File: rtl/pdm_tx.sv
// PCM to PDM transmitter: 2-entry sample FIFO feeding a first-order sigma-delta modulator
// whose bits are clocked out on a divided-down PDM clock.
module pdm_tx #(
  parameter int CLK_DIV = 66,
  parameter int OSR     = 64
) (
  input  logic     AHBclk,
  input  logic     rst,
  pdm_tx_if.slave  bus
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_RISE = CW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(OSR - 1);

  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [15:0]   acc;
  logic [15:0]   cur;
  logic          pdm_clk_r;
  logic          pdm_out_r;
  logic          underrun_r;

  logic [15:0]   fifo_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;

  logic          fall_tick;
  logic          rise_tick;
  logic          last_bit;
  logic          bsy_c;
  logic          load_start;
  logic          abort_req;
  logic          run_wrap;
  logic          pop;

  logic [15:0]   u;
  logic [16:0]   sum;

  assign fifo_empty = (fifo_count == 2'd0);
  assign fifo_full  = (fifo_count == 2'd2);
  assign fall_tick  = (cnt == CNT_LAST);
  assign rise_tick  = (cnt == CNT_RISE);
  assign last_bit   = (bit_cnt == BIT_LAST);

  // Offset-binary sample; the carry out of the 17-bit sum is the next PDM bit.
  assign u   = cur ^ 16'h8000;
  assign sum = {1'b0, acc} + {1'b0, u};

  always_ff @(posedge AHBclk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.ctrl == CMD_START) state_next = RUN;
      end
      RUN: begin
        if (bus.ctrl == CMD_ABORT)     state_next = IDLE;
        else if (bus.ctrl == CMD_STOP) state_next = STOPPING;
      end
      STOPPING: begin
        if (bus.ctrl == CMD_ABORT)      state_next = IDLE;
        else if (fall_tick && last_bit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A sample is consumed on START and at the end of every sample while running;
  // a STOP arriving on that very cycle still takes the RUN path.
  always_comb begin
    bsy_c      = (state != IDLE);
    load_start = (state == IDLE) && (bus.ctrl == CMD_START);
    abort_req  = (state != IDLE) && (bus.ctrl == CMD_ABORT);
    run_wrap   = (state == RUN) && !abort_req && fall_tick && last_bit;
    pop        = (load_start || run_wrap) && !fifo_empty;
    push       = bus.din_valid && !fifo_full;
  end

  // An abort flush wins over a simultaneous push.
  always_ff @(posedge AHBclk) begin
    if (!rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else if (abort_req) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bus.din;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge AHBclk) begin
    if (!rst) begin
      cnt        <= '0;
      bit_cnt    <= '0;
      acc        <= '0;
      cur        <= '0;
      pdm_clk_r  <= 1'b0;
      pdm_out_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else if (load_start) begin
      cnt        <= '0;
      bit_cnt    <= '0;
      acc        <= '0;
      pdm_clk_r  <= 1'b0;
      pdm_out_r  <= 1'b0;
      cur        <= fifo_empty ? 16'h0000 : fifo_mem[rd_ptr];
      underrun_r <= fifo_empty;
    end else if (state == IDLE || abort_req) begin
      cnt       <= '0;
      bit_cnt   <= '0;
      acc       <= '0;
      pdm_clk_r <= 1'b0;
      pdm_out_r <= 1'b0;
    end else begin
      cnt <= fall_tick ? '0 : cnt + 1'b1;
      if (rise_tick) pdm_clk_r <= 1'b1;
      // Data only moves on the PDM falling edge so it is settled for the receiver's rising edge.
      if (fall_tick) begin
        pdm_clk_r <= 1'b0;
        pdm_out_r <= sum[16];
        acc       <= sum[15:0];
        bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
        if (run_wrap) begin
          cur <= fifo_empty ? 16'h0000 : fifo_mem[rd_ptr];
          if (fifo_empty) underrun_r <= 1'b1;
        end
      end
    end
  end

  assign bus.din_ready = !fifo_full;
  assign bus.pdm_clk_o = pdm_clk_r;
  assign bus.pdm_out   = pdm_out_r;
  assign bus.bsy       = bsy_c;
  assign bus.underrun  = underrun_r;

endmodule

// File: tb/tb_pdm_tx.sv
// Bench for pdm_tx: a full-size instance streams a table of samples against a
// sigma-delta scoreboard; a small OSR=4 instance covers FIFO, stop, abort and reset corners.
module tb_pdm_tx;

  localparam int CLK_DIV_A = 66;
  localparam int OSR_A     = 64;
  localparam int CLK_DIV_B = 4;
  localparam int OSR_B     = 4;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  logic AHBclk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 AHBclk = ~AHBclk;

  pdm_tx_if bus_a ();
  pdm_tx_if bus_b ();

  pdm_tx #(.CLK_DIV(CLK_DIV_A), .OSR(OSR_A)) dut_a (
    .AHBclk (AHBclk),
    .rst    (rst_a),
    .bus    (bus_a)
  );

  pdm_tx #(.CLK_DIV(CLK_DIV_B), .OSR(OSR_B)) dut_b (
    .AHBclk (AHBclk),
    .rst    (rst_b),
    .bus    (bus_b)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] sample;
    int          exp_ones;
  } vec_t;

  vec_t vectors [5];

  bit          sb_bits [$];
  int          sb_ones [$];
  logic [15:0] model_acc = 16'h0000;

  logic prev_clk_a = 1'b0;
  int   bit_idx_a  = 0;
  int   ones_a     = 0;
  int   stream_idx = 0;

  logic prev_clk_b = 1'b0;
  bit   bits_b [$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Pushes one sample into instance A and queues the bits the modulator must emit for it.
  task automatic applyStimulus(input logic [15:0] sample, input int exp_ones);
    int          waited;
    logic [15:0] uu;
    logic [16:0] s;
    waited = 0;
    while (bus_a.din_ready !== 1'b1 && waited < 20000) begin
      @(negedge AHBclk);
      waited++;
    end
    if (bus_a.din_ready !== 1'b1) begin
      checkOutput("a_din_ready_timeout", 32'd0, 32'd1);
      return;
    end
    uu = sample ^ 16'h8000;
    for (int k = 0; k < OSR_A; k++) begin
      s = {1'b0, model_acc} + {1'b0, uu};
      sb_bits.push_back(s[16]);
      model_acc = s[15:0];
    end
    sb_ones.push_back(exp_ones);
    bus_a.din       = sample;
    bus_a.din_valid = 1'b1;
    @(negedge AHBclk);
    bus_a.din_valid = 1'b0;
  endtask

  task automatic cmdA(input logic [1:0] c);
    bus_a.ctrl = c;
    @(negedge AHBclk);
    bus_a.ctrl = CMD_NOP;
  endtask

  task automatic cmdB(input logic [1:0] c);
    bus_b.ctrl = c;
    @(negedge AHBclk);
    bus_b.ctrl = CMD_NOP;
  endtask

  task automatic pushB(input logic [15:0] sample);
    bus_b.din       = sample;
    bus_b.din_valid = 1'b1;
    @(negedge AHBclk);
    bus_b.din_valid = 1'b0;
  endtask

  task automatic waitBitsB(input int n, input string name);
    int waited;
    waited = 0;
    while (bits_b.size() < n && waited < 500) begin
      @(negedge AHBclk);
      waited++;
    end
    if (bits_b.size() < n) checkOutput(name, bits_b.size(), n);
  endtask

  // Each PDM falling edge on A delivers a new bit; compare it with the scoreboard.
  always @(negedge AHBclk) begin
    bit exp_b;
    int exp_o;
    if (prev_clk_a === 1'b1 && bus_a.pdm_clk_o === 1'b0 && sb_bits.size() > 0) begin
      exp_b = sb_bits.pop_front();
      checkOutput($sformatf("a_stream_bit%0d", stream_idx), bus_a.pdm_out, exp_b);
      stream_idx++;
      ones_a += (bus_a.pdm_out === 1'b1) ? 1 : 0;
      bit_idx_a++;
      if (bit_idx_a == OSR_A) begin
        exp_o = sb_ones.pop_front();
        checkOutput("a_sample_ones", ones_a, exp_o);
        ones_a    = 0;
        bit_idx_a = 0;
      end
    end
    prev_clk_a = bus_a.pdm_clk_o;
  end

  always @(negedge AHBclk) begin
    if (prev_clk_b === 1'b1 && bus_b.pdm_clk_o === 1'b0) bits_b.push_back(bus_b.pdm_out);
    prev_clk_b = bus_b.pdm_clk_o;
  end

  initial begin
    int          t;
    int          accepted;
    int          highs;
    logic [15:0] exp_b_bits;

    vectors[0] = '{16'h0000, 32};
    vectors[1] = '{16'h4000, 48};
    vectors[2] = '{16'h8000, 0};
    vectors[3] = '{16'hC000, 16};
    vectors[4] = '{16'h7FFF, 63};

    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.ctrl = CMD_NOP; bus_a.din = '0; bus_a.din_valid = 1'b0;
    bus_b.ctrl = CMD_NOP; bus_b.din = '0; bus_b.din_valid = 1'b0;
    repeat (3) @(negedge AHBclk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge AHBclk);

    checkOutput("a_reset_bsy",       bus_a.bsy,       1'b0);
    checkOutput("a_reset_underrun",  bus_a.underrun,  1'b0);
    checkOutput("a_reset_din_ready", bus_a.din_ready, 1'b1);
    checkOutput("a_reset_pdm_clk",   bus_a.pdm_clk_o, 1'b0);
    checkOutput("a_reset_pdm_out",   bus_a.pdm_out,   1'b0);

    // Instance A: table-driven streaming, plus PDM clock timing.
    applyStimulus(vectors[0].sample, vectors[0].exp_ones);
    applyStimulus(vectors[1].sample, vectors[1].exp_ones);
    cmdA(CMD_START);
    checkOutput("a_bsy_after_start", bus_a.bsy, 1'b1);

    t = 0;
    while (bus_a.pdm_clk_o !== 1'b1 && t < 200) begin
      @(negedge AHBclk);
      t++;
    end
    checkOutput("a_first_rise_delay", t, CLK_DIV_A / 2);
    t = 1;
    while (t < 200) begin
      @(negedge AHBclk);
      if (bus_a.pdm_clk_o !== 1'b1) break;
      t++;
    end
    checkOutput("a_clk_high_cycles", t, CLK_DIV_A / 2);
    t = 1;
    while (t < 200) begin
      @(negedge AHBclk);
      if (bus_a.pdm_clk_o !== 1'b0) break;
      t++;
    end
    checkOutput("a_clk_low_cycles", t, CLK_DIV_A / 2);

    for (int i = 2; i < 5; i++) applyStimulus(vectors[i].sample, vectors[i].exp_ones);
    checkOutput("a_underrun_while_fed", bus_a.underrun, 1'b0);

    t = 0;
    while ((sb_bits.size() > 0 || sb_ones.size() > 0) && t < 30000) begin
      @(negedge AHBclk);
      t++;
    end
    checkOutput("a_scoreboard_drained", sb_bits.size() + sb_ones.size(), 0);
    repeat (2) @(negedge AHBclk);
    checkOutput("a_underrun_after_starve", bus_a.underrun, 1'b1);
    checkOutput("a_bsy_midscale",          bus_a.bsy,      1'b1);
    cmdA(CMD_ABORT);
    checkOutput("a_abort_bsy",       bus_a.bsy,       1'b0);
    checkOutput("a_abort_pdm_clk",   bus_a.pdm_clk_o, 1'b0);
    checkOutput("a_abort_pdm_out",   bus_a.pdm_out,   1'b0);
    checkOutput("a_abort_din_ready", bus_a.din_ready, 1'b1);

    // Instance B: a held din_valid fills the FIFO after exactly two pushes.
    accepted = 0;
    bus_b.din_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus_b.din = 16'h1000 + 16'(k);
      if (bus_b.din_ready === 1'b1) accepted++;
      @(negedge AHBclk);
    end
    bus_b.din_valid = 1'b0;
    checkOutput("b_push_count",      accepted,        2);
    checkOutput("b_full_din_ready",  bus_b.din_ready, 1'b0);
    cmdB(CMD_START);
    checkOutput("b_start_din_ready", bus_b.din_ready, 1'b1);
    checkOutput("b_start_underrun",  bus_b.underrun,  1'b0);

    repeat (5) @(negedge AHBclk);
    cmdB(CMD_ABORT);
    checkOutput("b_abort_bsy",       bus_b.bsy,       1'b0);
    checkOutput("b_abort_pdm_clk",   bus_b.pdm_clk_o, 1'b0);
    checkOutput("b_abort_pdm_out",   bus_b.pdm_out,   1'b0);
    checkOutput("b_abort_din_ready", bus_b.din_ready, 1'b1);
    cmdB(CMD_START);
    checkOutput("b_flushed_underrun", bus_b.underrun, 1'b1);

    // Reset in the middle of a PDM period, with a sample left in the FIFO.
    pushB(16'h1234);
    @(negedge AHBclk);
    checkOutput("b_clk_high_mid_period", bus_b.pdm_clk_o, 1'b1);
    rst_b = 1'b0;
    @(negedge AHBclk);
    rst_b = 1'b1;
    checkOutput("b_reset_bsy",       bus_b.bsy,       1'b0);
    checkOutput("b_reset_pdm_clk",   bus_b.pdm_clk_o, 1'b0);
    checkOutput("b_reset_pdm_out",   bus_b.pdm_out,   1'b0);
    checkOutput("b_reset_underrun",  bus_b.underrun,  1'b0);
    checkOutput("b_reset_din_ready", bus_b.din_ready, 1'b1);

    // Two samples then starvation: 0000 / 0111 / midscale 1010, and STOP after bit 14.
    @(negedge AHBclk);
    bits_b.delete();
    pushB(16'h8000);
    pushB(16'h7FFF);
    cmdB(CMD_START);
    waitBitsB(4, "b_wait_bits4");
    checkOutput("b_underrun_fed", bus_b.underrun, 1'b0);
    waitBitsB(8, "b_wait_bits8");
    checkOutput("b_underrun_starved", bus_b.underrun, 1'b1);
    waitBitsB(14, "b_wait_bits14");
    cmdB(CMD_STOP);
    checkOutput("b_bsy_stopping", bus_b.bsy, 1'b1);
    t = 0;
    while (bus_b.bsy === 1'b1 && t < 100) begin
      @(negedge AHBclk);
      t++;
    end
    @(negedge AHBclk);
    checkOutput("b_stop_bsy",        bus_b.bsy,     1'b0);
    checkOutput("b_stop_bit_total",  bits_b.size(), 16);
    exp_b_bits = 16'b0000_0111_1010_1010;
    if (bits_b.size() >= 16) begin
      for (int k = 0; k < 16; k++)
        checkOutput($sformatf("b_bit%0d", k), bits_b[k], exp_b_bits[15-k]);
    end
    highs = 0;
    for (int k = 0; k < 3 * CLK_DIV_B; k++) begin
      if (bus_b.pdm_clk_o !== 1'b0) highs++;
      @(negedge AHBclk);
    end
    checkOutput("b_clk_idle_low",    highs,          0);
    checkOutput("b_idle_pdm_out",    bus_b.pdm_out,  1'b0);
    checkOutput("b_underrun_sticky", bus_b.underrun, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
